imm_ext_pipe: RTL and testbench
===============================

Name: imm_ext_pipe

Overview:
- Parametrised, multi-lane immediate extension stage for the dual-issue decode path.
- Extends one immediate per issue lane per transfer under a per-lane mode: zero, sign, upper (LUI) or branch-offset.
- Results sit in a 2-entry skid buffer with valid/ready handshakes on both sides, so a stalled execute stage never forces decode to recompute immediates.
- Also supports flush on branch mispredict or exception.

Parameters:
- LANES, 2, number of issue lanes extended per transfer.
- IMM_W, 16, immediate field width per lane.
- DATA_W, 32, extended result width per lane; must satisfy DATA_W >= IMM_W+2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous buffer clear (mispredict/exception).
- in_valid  input  1  upstream offers a transfer.
- in_ready  output  1  buffer can accept a transfer this cycle.
- in_imm  input  LANES*IMM_W  immediates; lane i at bits [i*IMM_W +: IMM_W].
- in_mode  input  LANES*2  per-lane mode; lane i at bits [i*2 +: 2].
- in_lane_en  input  LANES  per-lane enable; a disabled lane produces all zeros.
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream consumes head entry.
- out_data  output  LANES*DATA_W  extended results; lane i at bits [i*DATA_W +: DATA_W].
- occupancy  output  2  number of valid entries (0..2).

Behaviour:
- Mode encoding per lane, computed combinationally at the input and stored already extended:
  - 00: zero-extend imm to DATA_W.
  - 01: sign-extend imm from bit IMM_W-1.
  - 10: upper, {imm, (DATA_W-IMM_W) zeros}.
  - 11: branch offset, sign-extended imm shifted left 2; the upper 2 bits are discarded and the result is truncated to DATA_W.
  - Lanes with in_lane_en=0 store 0 regardless of mode.
- Storage is 2 entries managed as a FIFO, with a 1-bit head pointer, a 1-bit tail pointer and a 2-bit count.
- Push happens when in_valid && in_ready. Pop happens when out_valid && out_ready.
- in_ready = (count != 2). It depends only on registered state, never on out_ready. When full, no push occurs even if a pop happens in the same cycle.
- out_valid = (count != 0). out_data = entry at head; all zeros when count = 0.
- Latency: data accepted at edge N is visible on out_data with out_valid=1 after edge N. There is no combinational bypass from input to output.
- Simultaneous push and pop with count=1: count stays 1, both pointers advance, and the new entry becomes head after the edge.
- Push/pop ordering is strict FIFO; entries are never reordered or dropped except by flush/rst.
- Pointers wrap modulo 2.
- occupancy = count.
- flush=1 at an edge:
  - count, head and tail go to 0.
  - Any push or pop in that cycle is discarded.
  - Entry contents need not be cleared, but out_data must read 0 while empty.
- rst=1 at an edge has the same effect as flush and takes priority over flush.
- Reset values: in_ready=1, out_valid=0, out_data=0, occupancy=0.
- rst or flush asserted mid-stream, with count=2 and out_ready=1, discards both entries. The next cycle shows out_valid=0 and in_ready=1.
- X-safety: in_imm and in_mode are ignored when no push occurs; out_data must not go X after reset when empty.

Test Plan:
1. Reset: assert rst 2 cycles with in_valid=1 -> in_ready=1, out_valid=0, out_data=0, occupancy=0 throughout and after release.
2. Per-lane modes, defaults: lane0 imm=16'h8004, mode 01; lane1 imm=16'h8004, mode 11; lanes enabled, out_ready=1.
   - One cycle after the push: lane0 = 32'hFFFF8004, lane1 = 32'hFFFE0010.
   - Repeat with modes 00/10 -> 32'h00008004 and 32'h80040000.
3. Lane enable: lane_en=2'b01, lane1 imm=16'hFFFF, mode 01 -> lane1 result 32'h00000000; lane0 result is unaffected.
4. Backpressure/full: out_ready=0, push A then B -> occupancy=2, in_ready=0. Offer C with in_valid held -> C not accepted. Then out_ready=1 -> outputs A, B, C in order, one per cycle.
5. Simultaneous push/pop at count=1: stream 8 transfers with in_valid=1 and out_ready=1 continuously -> one result per cycle in order, occupancy stays 1, no bubbles after the first.
6. Flush with count=2 and in_valid=1 in the same cycle -> next cycle occupancy=0, out_valid=0, out_data=0. The flushed input never appears at the output. Repeat with rst and flush both high -> same result.

Source files
------------

// File: rtl/imm_ext_pipe.sv
// Multi-lane immediate extension stage: per-lane zero/sign/upper/branch extension
// feeding a 2-entry FIFO skid buffer with valid/ready on both sides and flush.
module imm_ext_pipe #(
   parameter int LANES  = 2,
   parameter int IMM_W  = 16,
   parameter int DATA_W = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [LANES*IMM_W-1:0]    in_imm,
   input  logic [LANES*2-1:0]        in_mode,
   input  logic [LANES-1:0]          in_lane_en,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [LANES*DATA_W-1:0]   out_data,
   output logic [1:0]                occupancy
);

   typedef enum logic [1:0] {
      MODE_ZERO   = 2'b00,
      MODE_SIGN   = 2'b01,
      MODE_UPPER  = 2'b10,
      MODE_BRANCH = 2'b11
   } mode_e;

   logic [LANES*DATA_W-1:0] mem [2];
   logic [LANES*DATA_W-1:0] ext;
   logic [IMM_W-1:0]        imm;
   logic [DATA_W-1:0]       sext;
   mode_e                   mode;
   logic                    head;
   logic                    tail;
   logic [1:0]              count;
   logic                    push;
   logic                    pop;

   always_comb begin
      ext  = '0;
      imm  = '0;
      sext = '0;
      mode = MODE_ZERO;
      for (int unsigned i = 0; i < LANES; i++) begin
         imm  = in_imm[i*IMM_W +: IMM_W];
         mode = mode_e'(in_mode[i*2 +: 2]);
         sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
         if (in_lane_en[i]) begin
            case (mode)
               MODE_ZERO:   ext[i*DATA_W +: DATA_W] = {{(DATA_W-IMM_W){1'b0}}, imm};
               MODE_SIGN:   ext[i*DATA_W +: DATA_W] = sext;
               MODE_UPPER:  ext[i*DATA_W +: DATA_W] = {imm, {(DATA_W-IMM_W){1'b0}}};
               MODE_BRANCH: ext[i*DATA_W +: DATA_W] = sext << 2;
               default:     ext[i*DATA_W +: DATA_W] = '0;
            endcase
         end
      end
   end

   // in_ready looks only at registered count, so a full buffer never pushes
   // even when the head is popped in the same cycle.
   assign in_ready  = (count != 2'd2);
   assign out_valid = (count != 2'd0);
   assign out_data  = out_valid ? mem[head] : '0;
   assign occupancy = count;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (push && !rst && !flush) mem[tail] <= ext;
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         count <= 2'd0;
         head  <= 1'b0;
         tail  <= 1'b0;
      end else begin
         if (push) tail <= ~tail;
         if (pop)  head <= ~head;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed, table-driven bench for imm_ext_pipe (LANES=2, IMM_W=16, DATA_W=32).
module tb_imm_ext_pipe;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_imm;
   logic [3:0]  in_mode;
   logic [1:0]  in_lane_en;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic [1:0]  occupancy;

   int n_cmp;
   int n_err;

   typedef struct {
      logic [31:0] imm;
      logic [3:0]  mode;
      logic [1:0]  en;
      logic [63:0] exp;
   } vec_t;

   vec_t vecs [7];

   imm_ext_pipe #(.LANES(2), .IMM_W(16), .DATA_W(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_imm     (in_imm),
      .in_mode    (in_mode),
      .in_lane_en (in_lane_en),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .occupancy  (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic [31:0] imm, input logic [3:0] mode, input logic [1:0] en);
      in_valid   = 1'b1;
      in_imm     = imm;
      in_mode    = mode;
      in_lane_en = en;
   endtask

   task automatic check_empty(input string name);
      check({name, ".in_ready"},  64'(in_ready),  64'd1);
      check({name, ".out_valid"}, 64'(out_valid), 64'd0);
      check({name, ".out_data"},  out_data,       64'd0);
      check({name, ".occupancy"}, 64'(occupancy), 64'd0);
   endtask

   task automatic fill_two(input logic [63:0] a, input logic [63:0] b);
      out_ready = 1'b0;
      drive({16'h0000, a[15:0]}, 4'b0000, 2'b01);
      cycle();
      drive({16'h0000, b[15:0]}, 4'b0000, 2'b01);
      cycle();
      in_valid = 1'b0;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;

      vecs[0] = '{32'h8004_8004, 4'b1101, 2'b11, 64'hFFFE0010_FFFF8004};
      vecs[1] = '{32'h8004_8004, 4'b1000, 2'b11, 64'h80040000_00008004};
      vecs[2] = '{32'hFFFF_8004, 4'b0101, 2'b01, 64'h00000000_FFFF8004};
      vecs[3] = '{32'h0001_7FFF, 4'b0111, 2'b11, 64'h00000001_0001FFFC};
      vecs[4] = '{32'hFFFF_FFFF, 4'b0101, 2'b00, 64'h00000000_00000000};
      vecs[5] = '{32'h1234_FFFF, 4'b0010, 2'b11, 64'h00001234_FFFF0000};
      vecs[6] = '{32'h4000_FFFF, 4'b1111, 2'b11, 64'h00010000_FFFFFFFC};

      // Reset held two cycles with in_valid asserted.
      rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
      drive(32'hDEAD_BEEF, 4'b1111, 2'b11);
      cycle();
      check_empty("rst_c1");
      cycle();
      check_empty("rst_c2");
      rst = 1'b0;
      in_valid = 1'b0;
      cycle();
      check_empty("rst_after");

      // Table: push one transfer, see it next cycle, let it drain.
      for (int i = 0; i < 7; i++) begin
         drive(vecs[i].imm, vecs[i].mode, vecs[i].en);
         cycle();
         in_valid = 1'b0;
         check($sformatf("vec%0d.out_valid", i), 64'(out_valid), 64'd1);
         check($sformatf("vec%0d.out_data", i),  out_data,       vecs[i].exp);
         check($sformatf("vec%0d.occupancy", i), 64'(occupancy), 64'd1);
         cycle();
         check($sformatf("vec%0d.drained", i),   64'(occupancy), 64'd0);
      end

      // Backpressure: A, B fill the buffer; C is offered but must wait.
      fill_two(64'hA, 64'hB);
      check("full.occupancy", 64'(occupancy), 64'd2);
      check("full.in_ready",  64'(in_ready),  64'd0);
      check("full.head",      out_data,       64'hA);
      drive(32'h0000_000C, 4'b0000, 2'b01);
      cycle();
      cycle();
      check("hold.occupancy", 64'(occupancy), 64'd2);
      check("hold.head",      out_data,       64'hA);
      out_ready = 1'b1;
      cycle();
      check("drain1.data",      out_data,       64'hB);
      check("drain1.occupancy", 64'(occupancy), 64'd1);
      cycle();
      in_valid = 1'b0;
      check("drain2.data",      out_data,       64'hC);
      check("drain2.occupancy", 64'(occupancy), 64'd1);
      cycle();
      check("drain3.occupancy", 64'(occupancy), 64'd0);

      // Continuous streaming at count=1: one result per cycle, in order.
      for (int k = 0; k < 8; k++) begin
         drive({16'hA000 + 16'(k), 16'h1000 + 16'(k)}, 4'b0000, 2'b11);
         cycle();
         check($sformatf("stream%0d.valid", k), 64'(out_valid), 64'd1);
         check($sformatf("stream%0d.data", k),  out_data,
               {32'h0000A000 + 32'(k), 32'h00001000 + 32'(k)});
         check($sformatf("stream%0d.occupancy", k), 64'(occupancy), 64'd1);
      end
      in_valid = 1'b0;
      cycle();
      check("stream.end", 64'(occupancy), 64'd0);

      // Flush with the buffer full and a transfer offered in the same cycle.
      fill_two(64'h1, 64'h2);
      check("preflush.occupancy", 64'(occupancy), 64'd2);
      out_ready = 1'b1;
      flush = 1'b1;
      drive(32'h0000_0077, 4'b0000, 2'b11);
      cycle();
      flush = 1'b0;
      in_valid = 1'b0;
      check_empty("flush");
      cycle();
      check_empty("flush_later");

      // Same again with rst and flush together.
      fill_two(64'h3, 64'h4);
      check("prerst.occupancy", 64'(occupancy), 64'd2);
      out_ready = 1'b1;
      rst = 1'b1;
      flush = 1'b1;
      drive(32'h0000_0055, 4'b0000, 2'b11);
      cycle();
      rst = 1'b0;
      flush = 1'b0;
      in_valid = 1'b0;
      check_empty("rstflush");
      cycle();
      check_empty("rstflush_later");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
